// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and the I2S transmitter.
// The master offers a left/right pair with in_valid; the slave accepts it when in_ready is high.
interface i2s_tx_if #(
  parameter int BITSIZE = 16
) ();
  logic signed [BITSIZE-1:0] left_in;
  logic signed [BITSIZE-1:0] right_in;
  logic                      in_valid;
  logic                      in_ready;

  modport master (output left_in, output right_in, output in_valid, input in_ready);
  modport slave  (input left_in, input right_in, input in_valid, output in_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: buffers one stereo pair and serialises it MSB first,
// one bclk after each lrclk edge, into the left (lrclk low) and right (lrclk high) slots.
module i2s_tx #(
  parameter int BITSIZE = 16
) (
  input  logic     bclk,
  input  logic     rstn,
  input  logic     lrclk,
  input  logic     enable,
  i2s_tx_if.slave  s_in,
  output logic     sdout,
  output logic     frame_load,
  output logic     underrun
);

  localparam int CW = $clog2(BITSIZE);
  localparam logic [CW-1:0] CNT_INIT = CW'(BITSIZE - 1);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_lrclk_d;
  logic                 w_fall;
  logic                 w_rise;
  logic                 w_load_left;
  logic                 w_load_right;
  logic                 w_xfer;
  logic [BITSIZE-1:0]   w_load_data;
  logic                 r_hold_full;
  logic [BITSIZE-1:0]   r_hold_left;
  logic [BITSIZE-1:0]   r_hold_right;
  logic [BITSIZE-1:0]   r_shadow;
  logic [BITSIZE-1:0]   r_shift;
  logic [CW-1:0]        r_cnt;
  logic                 r_sdout;
  logic                 r_frame_load;
  logic                 r_underrun;

  assign w_fall        = r_lrclk_d & ~lrclk;
  assign w_rise        = ~r_lrclk_d & lrclk;
  assign s_in.in_ready = ~r_hold_full;
  assign w_xfer        = s_in.in_valid & ~r_hold_full;

  assign sdout      = r_sdout;
  assign frame_load = r_frame_load;
  assign underrun   = r_underrun;

  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_lrclk_d <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_lrclk_d <= lrclk;
    end
  end

  // A fall seen while already in LEFT cannot occur without an intervening rise, so it is ignored.
  always_comb begin
    w_state_next = r_state;
    w_load_left  = 1'b0;
    w_load_right = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_next = LEFT;
          w_load_left  = 1'b1;
        end
      end
      LEFT: begin
        if (w_rise) begin
          w_state_next = RIGHT;
          w_load_right = 1'b1;
        end
      end
      RIGHT: begin
        if (w_fall) begin
          w_state_next = LEFT;
          w_load_left  = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_load_data = r_shadow;
    if (w_load_left) begin
      w_load_data = r_hold_full ? r_hold_left : '0;
    end
  end

  // Holding buffer: a pair offered on the load cycle itself lands here for the next frame.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      r_hold_full  <= 1'b0;
      r_hold_left  <= '0;
      r_hold_right <= '0;
      r_shadow     <= '0;
      r_frame_load <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (w_xfer) begin
        r_hold_left  <= s_in.left_in;
        r_hold_right <= s_in.right_in;
        r_hold_full  <= 1'b1;
      end else if (w_load_left && r_hold_full) begin
        r_hold_full <= 1'b0;
      end
      if (w_load_left) begin
        r_shadow <= r_hold_full ? r_hold_right : '0;
      end
      r_frame_load <= w_load_left & r_hold_full;
      r_underrun   <= r_underrun | (w_load_left & ~r_hold_full);
    end
  end

  // The load edge already registers the MSB, giving the one-bclk I2S delay; a new edge truncates.
  always_ff @(posedge bclk or negedge rstn) begin
    if (!rstn) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_sdout <= 1'b0;
    end else if (w_load_left || w_load_right) begin
      r_shift <= {w_load_data[BITSIZE-2:0], 1'b0};
      r_cnt   <= CNT_INIT;
      r_sdout <= enable & w_load_data[BITSIZE-1];
    end else if (r_cnt != '0) begin
      r_shift <= {r_shift[BITSIZE-2:0], 1'b0};
      r_cnt   <= r_cnt - CW'(1);
      r_sdout <= enable & r_shift[BITSIZE-1];
    end else begin
      r_sdout <= 1'b0;
    end
  end

endmodule
